// File: rtl/uart_tx_parity.sv
// rtl/uart_tx_parity.sv - UART transmitter: start, 8 data bits LSB first, optional parity, stop
//
// Purpose:
//   Serialises one byte per accepted request onto tx. The frame is a start bit (0),
//   eight data bits LSB first, an optional parity bit, and a stop bit (1). Each bit
//   lasts CLKS_PER_BIT clocks.
//
// Build option:
//   UART_TX_PARITY_EN - when defined, the PARITY state is included. The frame is
//   then 11 bits long, and PARITY_ODD selects even (0) or odd (1) parity. When the
//   macro is not defined, the frame is 8N1 (10 bits).
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tx_start  in   transmit request, accepted only while idle
//   tx_data   in   byte to send, captured when the request is accepted
//   tx        out  serial line, idle high, registered
//   tx_busy   out  high while a frame is in flight
//   tx_done   out  one-cycle pulse after the final stop-bit cycle

module uart_tx_parity #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`else
  logic          unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // The next line level is computed together with the next state. This keeps
  // tx registered, and the line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (cnt_q == CNT_LAST);

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          state_d = START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ PARITY_ODD;
`endif
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// tb/tb_uart_tx_parity.sv - randomized self-checking bench for uart_tx_parity against a frame model
module tb_uart_tx_parity;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_e, busy_e, done_e;
  logic       tx_o, busy_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_parity #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_e), .tx_busy(busy_e), .tx_done(done_e)
  );

  uart_tx_parity #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_o), .tx_busy(busy_o), .tx_done(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns the level of frame bit n for byte d: the start bit, the data bits
  // LSB first, the parity bit when it is present, and then the stop bit.
  function automatic logic frame_bit(input logic [7:0] d, input bit odd, input int n);
    int ones = 0;
    for (int k = 0; k < 8; k++) ones += d[k];
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
    if (n == 9 && NB == 11) return ((ones % 2) == 1) ^ odd;
    return 1'b1;
  endfunction

  // The caller is at a negedge. The request is accepted on the next posedge.
  // keep: hold tx_start high through the frame and return at the done cycle.
  // inject: pulse tx_start and change tx_data during the frame.
  task automatic run_frame(input logic [7:0] d, input bit inject, input bit keep);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep) tx_start = 1'b0;
    for (int i = 0; i < NB * CPB; i++) begin
      check($sformatf("tx_even[%0d]", i), tx_e, frame_bit(d, 1'b0, i / CPB));
      check($sformatf("tx_odd[%0d]", i),  tx_o, frame_bit(d, 1'b1, i / CPB));
      check($sformatf("busy[%0d]", i), {busy_e, busy_o}, 2'b11);
      check($sformatf("done[%0d]", i), {done_e, done_o}, 2'b00);
      if (inject && (i == 39 || i == 119)) begin
        tx_start = 1'b1;
        tx_data  = ~d;
      end else if (!keep) begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    check("done_pulse", {done_e, done_o}, 2'b11);
    check("busy_end", {busy_e, busy_o}, 2'b00);
    check("tx_gap", {tx_e, tx_o}, 2'b11);
    if (!keep) begin
      @(negedge clk);
      check("done_clear", {done_e, done_o}, 2'b00);
      check("tx_idle", {tx_e, tx_o}, 2'b11);
      check("busy_idle", {busy_e, busy_o}, 2'b00);
    end
  endtask

  initial begin
    #12;
    check("reset_tx", {tx_e, tx_o}, 2'b11);
    check("reset_busy", {busy_e, busy_o}, 2'b00);
    check("reset_done", {done_e, done_o}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(8'h03, 1'b0, 1'b0);
    run_frame(8'h07, 1'b0, 1'b0);
    run_frame(8'h00, 1'b0, 1'b0);
    run_frame(8'($urandom), 1'b1, 1'b0);

    run_frame(8'hA5, 1'b0, 1'b1);
    run_frame(8'hA5, 1'b0, 1'b1);
    run_frame(8'hA5, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of the DATA bits.
    tx_data  = 8'($urandom);
    tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    repeat (69) @(negedge clk);
    check("pre_reset_busy", {busy_e, busy_o}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx", {tx_e, tx_o}, 2'b11);
    check("async_busy", {busy_e, busy_o}, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_no_done", {done_e, done_o}, 2'b00);
      check("reset_hold_tx", {tx_e, tx_o}, 2'b11);
    end
    rst_n = 1'b1;
    run_frame(8'h55, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
